// File: rtl/riscv_fetch_buffer.sv
// Instruction fetch buffer: issues sequential word fetches on a req/gnt bus and
// queues in-order responses as {pc, instr} pairs for the IF stage, with redirect flush.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_fetch_buffer #(
  parameter int               DEPTH    = 4,
  parameter logic [`XLEN-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_fb_redirect,
  input  logic [`XLEN-1:0] i_fb_redirect_pc,
  output logic             o_fb_mem_req,
  output logic [`XLEN-1:0] o_fb_mem_addr,
  input  logic             i_fb_mem_gnt,
  input  logic             i_fb_mem_rvalid,
  input  logic [`XLEN-1:0] i_fb_mem_rdata,
  output logic             o_fb_valid,
  output logic [`XLEN-1:0] o_fb_instr,
  output logic [`XLEN-1:0] o_fb_pc,
  input  logic             i_fb_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic             run;
  logic [`XLEN-1:0] fetch_pc;
  logic [`XLEN-1:0] resp_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [`XLEN-1:0] pc_mem    [DEPTH];
  logic [`XLEN-1:0] instr_mem [DEPTH];

  logic [CW:0]      in_use;
  logic             accept;
  logic             push;
  logic             pop;
  logic [`XLEN-1:0] redirect_pc_aligned;
  logic             unused_pc_bits;

  // Every slot is either queued or still owed by the bus, so credits cover both.
  assign in_use              = {1'b0, outstanding} + {1'b0, count};
  assign o_fb_mem_req        = run & ~i_fb_redirect & (in_use < (CW+1)'(DEPTH));
  assign o_fb_mem_addr       = fetch_pc;
  assign accept              = o_fb_mem_req & i_fb_mem_gnt;
  assign push                = i_fb_mem_rvalid & ~i_fb_redirect & (drop == '0);
  assign pop                 = o_fb_valid & i_fb_ready & ~i_fb_redirect;
  assign redirect_pc_aligned = {i_fb_redirect_pc[`XLEN-1:2], 2'b00};
  assign unused_pc_bits      = ^i_fb_redirect_pc[1:0];

  assign o_fb_valid = (count != '0);
  assign o_fb_instr = instr_mem[rd_ptr];
  assign o_fb_pc    = pc_mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      run <= 1'b1;
      if (i_fb_redirect) begin
        // Everything still owed after this cycle's response belongs to the old stream.
        fetch_pc    <= redirect_pc_aligned;
        resp_pc     <= redirect_pc_aligned;
        outstanding <= outstanding - CW'(i_fb_mem_rvalid);
        drop        <= outstanding - CW'(i_fb_mem_rvalid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + `XLEN'(4);
        if (push) resp_pc <= resp_pc + `XLEN'(4);
        outstanding <= outstanding + CW'(accept) - CW'(i_fb_mem_rvalid);
        if (i_fb_mem_rvalid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (i_fb_redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= resp_pc;
        instr_mem[wr_ptr] <= i_fb_mem_rdata;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A response with nothing outstanding is a bus protocol violation.
  assert property (@(posedge i_clk) disable iff (!i_rstn)
                   i_fb_mem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Self-checking bench for riscv_fetch_buffer: directed scenarios plus randomized bus
// traffic compared each cycle against a queue-based model of requests and buffered entries.
module tb_riscv_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        fb_valid;
  logic [31:0] fb_instr;
  logic [31:0] fb_pc;
  logic        ready;

  riscv_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_fb_redirect    (redirect),
    .i_fb_redirect_pc (redirect_pc),
    .o_fb_mem_req     (mem_req),
    .o_fb_mem_addr    (mem_addr),
    .i_fb_mem_gnt     (gnt),
    .i_fb_mem_rvalid  (rvalid),
    .i_fb_mem_rdata   (rdata),
    .o_fb_valid       (fb_valid),
    .o_fb_instr       (fb_instr),
    .o_fb_pc          (fb_pc),
    .i_fb_ready       (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        m_pend[$];
  ent_t        m_fifo[$];
  bit          m_run;
  logic [31:0] m_fetch_pc;
  int          cyc;

  int checks;
  int errors;

  int p_gnt, p_ready, p_redirect, p_rvalid, lat_lo, lat_hi;
  bit          force_redir;
  logic [31:0] force_pc;

  logic        s_valid, s_req;
  logic [31:0] s_pc, s_instr, s_addr;
  int          acc_cnt;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_knobs(int g, int r, int rd, int rv, int lo, int hi);
    p_gnt = g; p_ready = r; p_redirect = rd; p_rvalid = rv; lat_lo = lo; lat_hi = hi;
  endtask

  // Bus responder answers the oldest request once its latency has elapsed.
  task automatic applyStimulus();
    bit rv;
    gnt   = ($urandom_range(99) < p_gnt);
    ready = ($urandom_range(99) < p_ready);
    rv    = (m_pend.size() > 0) && (m_pend[0].due <= cyc) && ($urandom_range(99) < p_rvalid);
    rvalid = rv;
    rdata  = rv ? instr_of(m_pend[0].addr) : $urandom();
    redirect    = force_redir || ($urandom_range(99) < p_redirect);
    redirect_pc = force_redir ? force_pc : $urandom();
    force_redir = 1'b0;
  endtask

  task automatic checkOutput();
    bit exp_valid, exp_req;
    exp_valid = (m_fifo.size() > 0);
    exp_req   = m_run && !redirect && ((m_pend.size() + m_fifo.size()) < DEPTH);
    check("valid", 32'(fb_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("pc", fb_pc, m_fifo[0].pc);
      check("instr", fb_instr, m_fifo[0].instr);
    end
    check("req", 32'(mem_req), 32'(exp_req));
    check("addr", mem_addr, m_fetch_pc);
  endtask

  task automatic update_model();
    bit   exp_req;
    req_t r;
    exp_req = m_run && !redirect && ((m_pend.size() + m_fifo.size()) < DEPTH);
    if (m_fifo.size() > 0 && ready && !redirect) void'(m_fifo.pop_front());
    if (rvalid) begin
      r = m_pend.pop_front();
      if (!r.stale && !redirect) m_fifo.push_back('{r.addr, rdata});
    end
    if (redirect) begin
      m_fifo.delete();
      foreach (m_pend[i]) m_pend[i].stale = 1'b1;
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else if (exp_req && gnt) begin
      m_pend.push_back('{m_fetch_pc, cyc + int'($urandom_range(lat_hi, lat_lo)), 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    m_run = 1'b1;
    cyc++;
  endtask

  task automatic cycle();
    applyStimulus();
    @(negedge clk);
    s_valid = fb_valid; s_pc = fb_pc; s_instr = fb_instr; s_req = mem_req; s_addr = mem_addr;
    if (mem_req && gnt) acc_cnt++;
    checkOutput();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gnt = 1'b0; ready = 1'b0; rvalid = 1'b0; rdata = '0; redirect = 1'b0; redirect_pc = '0;
  endtask

  // Entered one time unit after a rising edge; leaves reset released at the same phase.
  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_valid", 32'(fb_valid), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_pc", fb_pc, 32'h0);
    check("rst_instr", fb_instr, 32'h0);
    idle_inputs();
    m_pend.delete();
    m_fifo.delete();
    m_run      = 1'b0;
    m_fetch_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_first_valid(int budget, logic [31:0] exp_pc, string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (s_valid) begin
        check({name, "_pc"}, s_pc, exp_pc);
        check({name, "_instr"}, s_instr, instr_of(exp_pc));
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("[TB] FAIL %s timeout: got no valid expected pc %h", name, exp_pc);
    end
  endtask

  initial begin
    bit hit;
    checks = 0; errors = 0; cyc = 0; force_redir = 1'b0; force_pc = '0; acc_cnt = 0;
    m_run = 1'b0; m_fetch_pc = 32'h0;
    idle_inputs();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    check("por_valid", 32'(fb_valid), 32'd0);
    check("por_req", 32'(mem_req), 32'd0);
    check("por_pc", fb_pc, 32'h0);
    check("por_instr", fb_instr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Streaming at L=1: first entry three cycles after release, then one per cycle.
    set_knobs(100, 100, 0, 100, 1, 1);
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k < 3) check("A_novalid", 32'(s_valid), 32'd0);
      else begin
        check("A_valid", 32'(s_valid), 32'd1);
        check("A_pc", s_pc, 32'(4 * (k - 3)));
      end
    end

    // Consumer stalled: queue fills to DEPTH, then drains in order.
    async_reset();
    set_knobs(100, 0, 0, 100, 1, 1);
    acc_cnt = 0;
    repeat (20) cycle();
    check("B_accepts", 32'(acc_cnt), 32'd4);
    check("B_req_low", 32'(s_req), 32'd0);
    check("B_full_valid", 32'(s_valid), 32'd1);
    p_ready = 100;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("B_drain_pc", s_pc, 32'(4 * k));
      if (k == 0) check("B_no_req_full", 32'(s_req), 32'd0);
      if (k == 1) begin
        check("B_resume_req", 32'(s_req), 32'd1);
        check("B_resume_addr", s_addr, 32'h10);
      end
    end

    // Redirect with two requests in flight at L=3, then one coinciding with a response.
    async_reset();
    set_knobs(100, 100, 0, 100, 3, 3);
    repeat (3) cycle();
    force_redir = 1'b1; force_pc = 32'h200;
    cycle();
    check("C_redir_req", 32'(s_req), 32'd0);
    cycle();
    check("C_valid_clear", 32'(s_valid), 32'd0);
    check("C_new_req", 32'(s_req), 32'd1);
    check("C_new_addr", s_addr, 32'h200);
    wait_first_valid(16, 32'h200, "C_first");
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (m_pend.size() > 0 && m_pend[0].due <= cyc) begin hit = 1'b1; break; end
      cycle();
    end
    check("C_rvalid_found", 32'(hit), 32'd1);
    force_redir = 1'b1; force_pc = 32'h300;
    cycle();
    wait_first_valid(16, 32'h300, "C_rv_redir");

    // Grant withheld: address holds, redirect mid-stall realigns the address.
    async_reset();
    set_knobs(0, 100, 0, 100, 2, 2);
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("D_hold_addr", s_addr, 32'h0);
      check("D_hold_req", 32'(s_req), 32'd1);
    end
    force_redir = 1'b1; force_pc = 32'h103;
    cycle();
    check("D_redir_req", 32'(s_req), 32'd0);
    p_gnt = 100;
    cycle();
    check("D_new_addr", s_addr, 32'h100);
    wait_first_valid(16, 32'h100, "D_first");

    // Reset mid-stream with responses owed; the bus drops them across reset.
    async_reset();
    set_knobs(100, 0, 0, 100, 4, 4);
    repeat (7) cycle();
    async_reset();
    set_knobs(100, 100, 0, 100, 1, 1);
    wait_first_valid(8, 32'h0, "E_restart");

    // Randomized traffic with occasional wrap-around redirect and a mid-run reset.
    set_knobs(70, 70, 3, 80, 1, 5);
    for (int k = 0; k < 10000; k++) begin
      if (k % 2500 == 1200) begin force_redir = 1'b1; force_pc = 32'hFFFF_FFF5; end
      if (k == 5000) async_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
